// File: rtl/fir_pkg.sv
// Shared constants and arithmetic helpers for the programmable streaming FIR.
// Helpers work on 64-bit signed values so one function serves every width.
package fir_pkg;

    localparam int RS_W         = 64;
    localparam int DEFAULT_TAPS = 15;

    // 15-tap lowpass reference set
    localparam logic signed [7:0] DEFAULT_COEFFS [DEFAULT_TAPS] = '{
        -8'sd2, -8'sd3, -8'sd4, 8'sd0, 8'sd9, 8'sd21, 8'sd32, 8'sd36,
        8'sd32, 8'sd21, 8'sd9, 8'sd0, -8'sd4, -8'sd3, -8'sd2
    };

    function automatic int acc_width(input int data_w, input int coeff_w, input int taps);
        return data_w + coeff_w + $clog2(taps);
    endfunction

    // Round half up by 2^shift, then clamp to the signed out_width range.
    function automatic logic signed [RS_W-1:0] round_sat(
        input logic signed [RS_W-1:0] acc,
        input int                     shift,
        input int                     out_width
    );
        logic signed [RS_W-1:0] r;
        logic signed [RS_W-1:0] max_v;
        logic signed [RS_W-1:0] min_v;
        if (shift > 0) begin
            r = (acc + (64'sd1 <<< (shift - 1))) >>> shift;
        end else begin
            r = acc;
        end
        max_v = (64'sd1 <<< (out_width - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (out_width - 1));
        if (r > max_v) begin
            return max_v;
        end else if (r < min_v) begin
            return min_v;
        end else begin
            return r;
        end
    endfunction

endpackage

// File: rtl/fir_out_stage.sv
// Registered AXI-Stream output stage: loads a new result on accept and holds
// data/last stable until the downstream consumer takes it.
module fir_out_stage #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] y_data,
    input  logic              y_last,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    logic              valid_r;
    logic [DATA_W-1:0] data_r;
    logic              last_r;

    // Output register: load on accept, retire on handshake, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            data_r  <= {DATA_W{1'b0}};
            last_r  <= 1'b0;
        end else if (load) begin
            valid_r <= 1'b1;
            data_r  <= y_data;
            last_r  <= y_last;
        end else if (out_ready) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign out_valid = valid_r;
    assign out_data  = data_r;
    assign out_last  = last_r;

endmodule

// File: rtl/fir_stream_prog.sv
// Transposed-form AXI-Stream FIR with runtime-programmable coefficients,
// rounding/saturating output scaling and optional flush on tlast.
module fir_stream_prog
    import fir_pkg::*;
#(
    parameter int NUM_TAPS               = 15,
    parameter int DATA_WIDTH             = 16,
    parameter int COEFF_WIDTH            = 8,
    parameter int OUT_SHIFT              = 7,
    parameter int C_S00_AXIS_TDATA_WIDTH = 32,
    parameter int C_M00_AXIS_TDATA_WIDTH = 32,
    parameter int OUT_WIDTH              = 16,
    parameter int CLEAR_ON_TLAST         = 0
) (
    input  logic                                s00_axis_aclk,
    input  logic                                s00_axis_aresetn,
    input  logic                                s00_axis_tvalid,
    output logic                                s00_axis_tready,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
    input  logic                                s00_axis_tlast,
    output logic                                m00_axis_tvalid,
    input  logic                                m00_axis_tready,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
    output logic                                m00_axis_tlast,
    output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
    input  logic                                coeff_we,
    input  logic [$clog2(NUM_TAPS)-1:0]         coeff_addr,
    input  logic [COEFF_WIDTH-1:0]              coeff_wdata,
    input  logic                                state_clear
);

    localparam int ACC_W  = acc_width(DATA_WIDTH, COEFF_WIDTH, NUM_TAPS);
    localparam int ADDR_W = $clog2(NUM_TAPS);
    localparam int STRB_W = C_M00_AXIS_TDATA_WIDTH / 8;

    logic signed [COEFF_WIDTH-1:0]       coeff_r [NUM_TAPS];
    logic signed [ACC_W-1:0]             psum_r  [1:NUM_TAPS-1];
    logic signed [ACC_W-1:0]             prod_s  [NUM_TAPS];
    logic signed [DATA_WIDTH-1:0]        x_s;
    logic signed [ACC_W-1:0]             tail_s;
    logic signed [ACC_W-1:0]             y_s;
    logic [C_M00_AXIS_TDATA_WIDTH-1:0]   y_scaled_s;
    logic                                s_ready_s;
    logic                                m_valid_s;
    logic                                accept_s;
    logic                                tlast_clear_s;
    logic                                coeff_hit_s;
    logic                                unused_tdata_s;

    assign x_s             = $signed(s00_axis_tdata[DATA_WIDTH-1:0]);
    assign unused_tdata_s  = ^s00_axis_tdata;
    assign s_ready_s       = ~m_valid_s | m00_axis_tready;
    assign s00_axis_tready = s_ready_s;
    assign accept_s        = s00_axis_tvalid & s_ready_s;
    assign tlast_clear_s   = (CLEAR_ON_TLAST != 0) ? (accept_s & s00_axis_tlast) : 1'b0;
    assign coeff_hit_s     = coeff_we & ({1'b0, coeff_addr} < (ADDR_W + 1)'(NUM_TAPS));

    for (genvar k = 0; k < NUM_TAPS; k++) begin : g_prod
        assign prod_s[k] = ACC_W'(coeff_r[k]) * ACC_W'(x_s);
    end

    // A simultaneous state_clear makes the current beat see an empty delay line.
    assign tail_s     = state_clear ? {ACC_W{1'b0}} : psum_r[1];
    assign y_s        = prod_s[0] + tail_s;
    assign y_scaled_s = C_M00_AXIS_TDATA_WIDTH'(round_sat(64'(y_s), OUT_SHIFT, OUT_WIDTH));

    // Coefficient bank: single-entry write port, out-of-range addresses dropped.
    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                coeff_r[k] <= {COEFF_WIDTH{1'b0}};
            end
        end else if (coeff_hit_s) begin
            coeff_r[coeff_addr] <= coeff_wdata;
        end else begin
            coeff_r <= coeff_r;
        end
    end

    // Transposed delay line: advances only on accepted beats, flushes on clear.
    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            for (int k = 1; k < NUM_TAPS; k++) begin
                psum_r[k] <= {ACC_W{1'b0}};
            end
        end else if (state_clear | tlast_clear_s) begin
            for (int k = 1; k < NUM_TAPS; k++) begin
                psum_r[k] <= {ACC_W{1'b0}};
            end
        end else if (accept_s) begin
            for (int k = 1; k < NUM_TAPS - 1; k++) begin
                psum_r[k] <= prod_s[k] + psum_r[k+1];
            end
            psum_r[NUM_TAPS-1] <= prod_s[NUM_TAPS-1];
        end else begin
            psum_r <= psum_r;
        end
    end

    fir_out_stage #(
        .DATA_W (C_M00_AXIS_TDATA_WIDTH)
    ) u_out_stage (
        .clk       (s00_axis_aclk),
        .rst_n     (s00_axis_aresetn),
        .load      (accept_s),
        .y_data    (y_scaled_s),
        .y_last    (s00_axis_tlast),
        .out_ready (m00_axis_tready),
        .out_valid (m_valid_s),
        .out_data  (m00_axis_tdata),
        .out_last  (m00_axis_tlast)
    );

    assign m00_axis_tvalid = m_valid_s;
    assign m00_axis_tstrb  = {STRB_W{1'b1}};

endmodule
